// File: rtl/stream_merge2_16b.sv
// Two-source 16-bit stream merger: round-robin grant into a single registered
// output slot that carries the source index and per-source transfer counters.
module stream_merge2_16b #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic [WIDTH-1:0] i_X0,
   input  logic             i_Valid0,
   output logic             o_Ready0,
   input  logic [WIDTH-1:0] i_X1,
   input  logic             i_Valid1,
   output logic             o_Ready1,
   output logic [WIDTH-1:0] o_Y,
   output logic             o_Sel,
   output logic             o_Valid,
   input  logic             i_Ready,
   output logic [CNT_W-1:0] o_Count0,
   output logic [CNT_W-1:0] o_Count1
);

   logic prio;
   logic space;
   logic any_valid;
   logic grant;
   logic accept;

   // Grant: a lone valid source wins; on a tie the priority pointer decides.
   always_comb begin
      space     = !o_Valid || i_Ready;
      any_valid = i_Valid0 || i_Valid1;
      grant     = 1'b0;
      if (i_Valid0 && i_Valid1) begin
         grant = prio;
      end else if (i_Valid1) begin
         grant = 1'b1;
      end
      accept   = space && any_valid;
      o_Ready0 = accept && !grant;
      o_Ready1 = accept && grant;
   end

   // Output slot: a new word may replace a draining one in the same cycle.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Y      <= '0;
         o_Sel    <= 1'b0;
         o_Valid  <= 1'b0;
         prio     <= 1'b0;
         o_Count0 <= '0;
         o_Count1 <= '0;
      end else if (accept) begin
         o_Y     <= grant ? i_X1 : i_X0;
         o_Sel   <= grant;
         o_Valid <= 1'b1;
         prio    <= ~grant;
         if (grant) begin
            o_Count1 <= o_Count1 + CNT_W'(1);
         end else begin
            o_Count0 <= o_Count0 + CNT_W'(1);
         end
      end else if (o_Valid && i_Ready) begin
         o_Valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_merge2_16b.sv
// Bench for stream_merge2_16b: directed vector table, then randomized traffic
// and a counter-wrap burst checked against a served-last arbitration model.
module tb_stream_merge2_16b;

   logic        clk;
   logic        rst;
   logic [15:0] x0, x1;
   logic        v0, v1, rdy;
   logic        r0, r1;
   logic [15:0] y;
   logic        sel, ov;
   logic [7:0]  c0, c1;

   int total  = 0;
   int passed = 0;

   stream_merge2_16b dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_X0(x0), .i_Valid0(v0), .o_Ready0(r0),
      .i_X1(x1), .i_Valid1(v1), .o_Ready1(r1),
      .o_Y(y), .o_Sel(sel), .o_Valid(ov), .i_Ready(rdy),
      .o_Count0(c0), .o_Count1(c1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst, v0, v1, rdy;
      logic [15:0] x0, x1;
      bit          ck;          // compare readies (skipped while state is unknown)
      bit          r0, r1;
      bit          ov, sel;
      logic [15:0] y;
      logic [7:0]  c0, c1;
   } vec_t;

   function automatic vec_t mk(bit rs, bit a0, logic [15:0] d0, bit a1, logic [15:0] d1,
                               bit rd, bit ck, bit e0, bit e1, bit ev, logic [15:0] ey,
                               bit es, logic [7:0] ec0, logic [7:0] ec1);
      vec_t v;
      v.rst = rs; v.v0 = a0; v.x0 = d0; v.v1 = a1; v.x1 = d1; v.rdy = rd;
      v.ck = ck; v.r0 = e0; v.r1 = e1; v.ov = ev; v.y = ey; v.sel = es;
      v.c0 = ec0; v.c1 = ec1;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(bit rs, bit a0, logic [15:0] d0, bit a1, logic [15:0] d1, bit rd);
      rst = rs; v0 = a0; x0 = d0; v1 = a1; x1 = d1; rdy = rd;
   endtask

   // Reference model: one output slot; on a tie the source served last loses.
   bit          m_valid;
   logic [15:0] m_y;
   bit          m_sel;
   int          m_last;      // -1 after reset: source 0 wins the first tie
   int          m_cnt[2];

   task automatic model_reset();
      m_valid = 0; m_y = '0; m_sel = 0; m_last = -1; m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   // One cycle of model-checked traffic.
   task automatic cycle(bit rs, bit a0, logic [15:0] d0, bit a1, logic [15:0] d1, bit rd);
      bit room;
      int win;
      drive(rs, a0, d0, a1, d1, rd);
      #1;
      room = !m_valid || rd;
      if (a0 && a1) win = (m_last == 0) ? 1 : 0;
      else if (a0)  win = 0;
      else if (a1)  win = 1;
      else          win = -1;
      check("ready0", 32'(r0), 32'(room && win == 0));
      check("ready1", 32'(r1), 32'(room && win == 1));
      if (rs) begin
         model_reset();
      end else if (room && win >= 0) begin
         m_valid = 1; m_y = (win == 1) ? d1 : d0; m_sel = (win == 1);
         m_last = win; m_cnt[win] = (m_cnt[win] + 1) % 256;
      end else if (m_valid && rd) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
      check("valid", 32'(ov), 32'(m_valid));
      check("y", 32'(y), 32'(m_y));
      check("sel", 32'(sel), 32'(m_sel));
      check("count0", 32'(c0), 32'(m_cnt[0]));
      check("count1", 32'(c1), 32'(m_cnt[1]));
   endtask

   vec_t tbl[23];

   initial begin
      drive(1, 0, '0, 0, '0, 0);
      model_reset();
      //            rst v0 x0       v1 x1       rdy ck r0 r1 ov y        sel c0 c1
      tbl[0]  = mk(1, 1, 16'h0000, 1, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
      tbl[1]  = mk(1, 1, 16'h0000, 1, 16'h0000, 1, 1, 1, 0, 0, 16'h0000, 0, 0, 0);
      tbl[2]  = mk(0, 1, 16'h1111, 0, 16'h0000, 1, 1, 1, 0, 1, 16'h1111, 0, 1, 0);
      tbl[3]  = mk(0, 1, 16'h2222, 0, 16'h0000, 1, 1, 1, 0, 1, 16'h2222, 0, 2, 0);
      tbl[4]  = mk(0, 1, 16'h3333, 0, 16'h0000, 1, 1, 1, 0, 1, 16'h3333, 0, 3, 0);
      tbl[5]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h3333, 0, 3, 0);
      tbl[6]  = mk(1, 1, 16'h0000, 1, 16'h0000, 1, 1, 0, 1, 0, 16'h0000, 0, 0, 0);
      tbl[7]  = mk(0, 1, 16'hA000, 1, 16'hB000, 1, 1, 1, 0, 1, 16'hA000, 0, 1, 0);
      tbl[8]  = mk(0, 1, 16'hA001, 1, 16'hB000, 1, 1, 0, 1, 1, 16'hB000, 1, 1, 1);
      tbl[9]  = mk(0, 1, 16'hA001, 1, 16'hB001, 1, 1, 1, 0, 1, 16'hA001, 0, 2, 1);
      tbl[10] = mk(0, 1, 16'hA002, 1, 16'hB001, 1, 1, 0, 1, 1, 16'hB001, 1, 2, 2);
      tbl[11] = mk(0, 1, 16'hBEEF, 0, 16'h0000, 1, 1, 1, 0, 1, 16'hBEEF, 0, 3, 2);
      tbl[12] = mk(0, 1, 16'hC000, 1, 16'hD000, 0, 1, 0, 0, 1, 16'hBEEF, 0, 3, 2);
      tbl[13] = mk(0, 1, 16'hC000, 1, 16'hD000, 0, 1, 0, 0, 1, 16'hBEEF, 0, 3, 2);
      tbl[14] = mk(0, 1, 16'hC000, 1, 16'hD000, 0, 1, 0, 0, 1, 16'hBEEF, 0, 3, 2);
      tbl[15] = mk(0, 1, 16'hC000, 1, 16'hD000, 1, 1, 0, 1, 1, 16'hD000, 1, 3, 3);
      tbl[16] = mk(0, 0, 16'h0000, 1, 16'hD001, 1, 1, 0, 1, 1, 16'hD001, 1, 3, 4);
      tbl[17] = mk(0, 1, 16'hC001, 1, 16'hD002, 1, 1, 1, 0, 1, 16'hC001, 0, 4, 4);
      tbl[18] = mk(1, 1, 16'hC002, 1, 16'hD002, 1, 1, 0, 1, 0, 16'h0000, 0, 0, 0);
      tbl[19] = mk(0, 1, 16'hE000, 1, 16'hE100, 1, 1, 1, 0, 1, 16'hE000, 0, 1, 0);
      tbl[20] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 1, 16'hE000, 0, 1, 0);
      tbl[21] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 0, 16'hE000, 0, 1, 0);
      tbl[22] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 0, 16'hE000, 0, 1, 0);

      @(posedge clk);
      #1;
      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].rst, tbl[i].v0, tbl[i].x0, tbl[i].v1, tbl[i].x1, tbl[i].rdy);
         #1;
         if (tbl[i].ck) begin
            check($sformatf("tbl%0d ready0", i), 32'(r0), 32'(tbl[i].r0));
            check($sformatf("tbl%0d ready1", i), 32'(r1), 32'(tbl[i].r1));
         end
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d valid", i), 32'(ov), 32'(tbl[i].ov));
         check($sformatf("tbl%0d y", i), 32'(y), 32'(tbl[i].y));
         check($sformatf("tbl%0d sel", i), 32'(sel), 32'(tbl[i].sel));
         check($sformatf("tbl%0d count0", i), 32'(c0), 32'(tbl[i].c0));
         check($sformatf("tbl%0d count1", i), 32'(c1), 32'(tbl[i].c1));
      end

      // Randomized traffic with occasional resets.
      cycle(1, 0, '0, 0, '0, 1);
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 16'($urandom),
               ($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 3) != 0));
      end

      // Counter wrap: 256 words from source 1 only.
      cycle(1, 0, '0, 0, '0, 1);
      for (int i = 0; i < 256; i++) begin
         cycle(0, 0, '0, 1, 16'(16'h5000 + i), 1);
         if (i == 254) check("wrap count1 at 255", 32'(c1), 32'd255);
      end
      check("wrap count1 to 0", 32'(c1), 32'd0);
      check("wrap count0 unchanged", 32'(c0), 32'd0);
      check("wrap last word", 32'(y), 32'h50FF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
